timer_arb: RTL and testbench

Shares the 16-bit bus port of one `timer` peripheral between NREQ hardware requesters, such as CPU core and DMA/sequencer. Arbitrates round-robin and runs each request as an uninterrupted sequence of timer bus cycles. Splits 32-bit counter reads and max-value writes into low/high halves that are never interleaved with another requester, so a 32-bit read always returns a coherent counter snapshot. Sits between the requesters and the `timer` sel/read/write/addr/data pins.

---
 rtl/timer_arb.sv | 215 +++++++++++++++++++++
 tb/tb_timer_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arb.sv
// timer_arb
//   Shares the 16-bit bus port of one timer peripheral between NREQ hardware
//   requesters. Requests are granted round-robin and each one runs as an
//   uninterrupted sequence of timer bus cycles. 32-bit counter reads and
//   max-value writes are split into a low half followed by a high half, and
//   nothing from another requester can fall between them. Because the timer
//   latches the whole counter on the low read, a 32-bit read always returns
//   one coherent snapshot.
//
// Build option:
//   TIMER_ARB_FIXED_PRIO_EN - when defined, the lowest requesting index always
//                             wins and no round-robin pointer is built.
//
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   req_i           per-requester request, held with payload until ack
//   we_i            per-requester write enable (1 = write, 0 = read)
//   addr_i          per-requester 2-bit address (00/01 pair, 10 status, 11 control)
//   wdata_i         per-requester 32-bit write data
//   ack_o           one-hot, one-cycle completion pulse
//   rdata_o         read data, valid in the ack cycle, held until the next ack
//   tmr_sel_o       timer select
//   tmr_read_o      timer read strobe
//   tmr_write_o     timer write strobe
//   tmr_addr_o      timer address
//   tmr_data_o      timer write data
//   tmr_data_i      timer read data, valid the cycle after the read strobe
module timer_arb #(
    parameter int NREQ = 2
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ-1:0]     we_i,
    input  logic [2*NREQ-1:0]   addr_i,
    input  logic [32*NREQ-1:0]  wdata_i,
    output logic [NREQ-1:0]     ack_o,
    output logic [31:0]         rdata_o,
    output logic                tmr_sel_o,
    output logic                tmr_read_o,
    output logic                tmr_write_o,
    output logic [1:0]          tmr_addr_o,
    output logic [15:0]         tmr_data_o,
    input  logic [15:0]         tmr_data_i
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, P0, P1, FIN} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic            we_q, we_d;
    logic [1:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [15:0]     lo_q, lo_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            sel_q, sel_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [1:0]      taddr_q, taddr_d;
    logic [15:0]     tdata_q, tdata_d;
`ifndef TIMER_ARB_FIXED_PRIO_EN
    logic [GW-1:0]   ptr_q, ptr_d;
`endif

    int          pick;
    logic        pick_we;
    logic [1:0]  pick_addr;
    logic [31:0] pick_wdata;
    logic [31:0] fin_rdata;

    // Winner selection. Loops run from the least to the most preferred
    // candidate so the last assignment is the winner.
    always_comb begin : arbitrate
        pick = 0;
`ifdef TIMER_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) pick = i;
        end
`else
        for (int k = NREQ; k >= 1; k--) begin
            if (req_i[(int'(ptr_q) + k) % NREQ]) pick = (int'(ptr_q) + k) % NREQ;
        end
`endif
    end

    always_comb begin : select_payload
        pick_we    = we_i[pick];
        pick_addr  = addr_i[2*pick +: 2];
        pick_wdata = wdata_i[32*pick +: 32];
    end

    // Read data presented during FIN. The high half (or the single-access
    // word) only arrives from the timer in this cycle, so it is passed
    // straight through and captured into rdata_q on the way out of FIN.
    always_comb begin : fin_data
        fin_rdata = 32'h0;
        if (!we_q) begin
            fin_rdata = addr_q[1] ? {16'h0, tmr_data_i} : {tmr_data_i, lo_q};
        end
    end

    // Next-state and next-output logic. Bus outputs are computed for the
    // state being entered so the registered strobes line up with P0/P1.
    always_comb begin : next_state
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        ack_d   = '0;
        sel_d   = 1'b0;
        read_d  = 1'b0;
        write_d = 1'b0;
        taddr_d = 2'b00;
        tdata_d = 16'h0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d = GW'(pick);
                    we_d    = pick_we;
                    addr_d  = pick_addr;
                    wdata_d = pick_wdata;
`ifndef TIMER_ARB_FIXED_PRIO_EN
                    ptr_d   = GW'(pick);
`endif
                    sel_d   = 1'b1;
                    read_d  = !pick_we;
                    write_d = pick_we;
                    taddr_d = pick_addr[1] ? pick_addr : 2'b00;
                    tdata_d = pick_wdata[15:0];
                    state_d = P0;
                end
            end
            P0: begin
                if (!addr_q[1]) begin
                    sel_d   = 1'b1;
                    read_d  = !we_q;
                    write_d = we_q;
                    taddr_d = 2'b01;
                    tdata_d = wdata_q[31:16];
                    state_d = P1;
                end else begin
                    ack_d[grant_q] = 1'b1;
                    state_d        = FIN;
                end
            end
            P1: begin
                lo_d           = we_q ? 16'h0 : tmr_data_i;
                ack_d[grant_q] = 1'b1;
                state_d        = FIN;
            end
            FIN: begin
                rdata_d = fin_rdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All state and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= 2'b00;
            wdata_q <= 32'h0;
            lo_q    <= 16'h0;
            rdata_q <= 32'h0;
            ack_q   <= '0;
            sel_q   <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            taddr_q <= 2'b00;
            tdata_q <= 16'h0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            ptr_q   <= GW'(NREQ - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            sel_q   <= sel_d;
            read_q  <= read_d;
            write_q <= write_d;
            taddr_q <= taddr_d;
            tdata_q <= tdata_d;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign ack_o       = ack_q;
    assign rdata_o     = (state_q == FIN) ? fin_rdata : rdata_q;
    assign tmr_sel_o   = sel_q;
    assign tmr_read_o  = read_q;
    assign tmr_write_o = write_q;
    assign tmr_addr_o  = taddr_q;
    assign tmr_data_o  = tdata_q;

endmodule

// File: tb/tb_timer_arb.sv
// tb_timer_arb
//   Directed bench for timer_arb with two requesters. A small behavioural
//   timer sits on the bus: a 32-bit counter that wraps at a programmable max
//   (setting an irq flag), latches a snapshot on the low counter read, and
//   returns read data one cycle after the read strobe.
module tb_timer_arb;

    localparam int NREQ = 2;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [3:0]  addr_i;
    logic [63:0] wdata_i;
    logic [1:0]  ack_o;
    logic [31:0] rdata_o;
    logic        tmr_sel_o;
    logic        tmr_read_o;
    logic        tmr_write_o;
    logic [1:0]  tmr_addr_o;
    logic [15:0] tmr_data_o;
    logic [15:0] tmr_data_i;

    int total = 0;
    int bad   = 0;

    timer_arb #(.NREQ(NREQ)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .ack_o      (ack_o),
        .rdata_o    (rdata_o),
        .tmr_sel_o  (tmr_sel_o),
        .tmr_read_o (tmr_read_o),
        .tmr_write_o(tmr_write_o),
        .tmr_addr_o (tmr_addr_o),
        .tmr_data_o (tmr_data_o),
        .tmr_data_i (tmr_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural timer sharing the arbiter reset.
    logic [31:0] cnt, max_v, snap, load_val;
    logic        en, irq, load_en;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt        <= 32'h0;
            max_v      <= 32'hFFFF_FFFF;
            snap       <= 32'h0;
            en         <= 1'b0;
            irq        <= 1'b0;
            tmr_data_i <= 16'h0;
        end else begin
            if (en) begin
                if (cnt >= max_v) begin
                    cnt <= 32'h0;
                    irq <= 1'b1;
                end else begin
                    cnt <= cnt + 32'h1;
                end
            end
            if (load_en) cnt <= load_val;
            if (tmr_sel_o && tmr_write_o) begin
                case (tmr_addr_o)
                    2'b00: begin max_v[15:0]  <= tmr_data_o; cnt <= 32'h0; end
                    2'b01: begin max_v[31:16] <= tmr_data_o; cnt <= 32'h0; end
                    2'b10: irq <= 1'b0;
                    2'b11: en  <= tmr_data_o[0];
                endcase
            end
            if (tmr_sel_o && tmr_read_o) begin
                case (tmr_addr_o)
                    2'b00: begin tmr_data_i <= cnt[15:0]; snap <= cnt; end
                    2'b01: tmr_data_i <= snap[31:16];
                    2'b10: tmr_data_i <= {15'h0, irq};
                    2'b11: tmr_data_i <= {15'h0, en};
                endcase
            end
        end
    end

    // Flags any cycle where a low-half read is not immediately followed by
    // its high-half read.
    logic prev_lo_rd = 1'b0;
    int   pair_err   = 0;

    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (prev_lo_rd && !(tmr_sel_o && tmr_read_o && tmr_addr_o == 2'b01)) pair_err++;
            prev_lo_rd = tmr_sel_o && tmr_read_o && (tmr_addr_o == 2'b00);
        end else begin
            prev_lo_rd = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] bus_word();
        return {11'h0, tmr_sel_o, tmr_read_o, tmr_write_o, tmr_addr_o, tmr_data_o};
    endfunction

    function automatic logic [31:0] exp_bus(input logic sel, input logic rd, input logic wr,
                                            input logic [1:0] a, input logic [15:0] d);
        return {11'h0, sel, rd, wr, a, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic we, input logic [1:0] a,
                                 input logic [31:0] d);
        we_i[idx]           = we;
        addr_i[2*idx +: 2]  = a;
        wdata_i[32*idx +: 32] = d;
        req_i[idx]          = 1'b1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Waits for an ack, then checks which requester got it and how many
    // clock edges passed since the call.
    task automatic wait_ack(input string tag, input logic [1:0] exp_ack, input int exp_edges);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (ack_o == 2'b00 && n < 12);
        checkOutput({tag, "_ack"}, 32'(ack_o), 32'(exp_ack));
        checkOutput({tag, "_edges"}, 32'(n), 32'(exp_edges));
    endtask

    // Drops a request in the ack cycle and moves into the following IDLE.
    task automatic finish_txn(input int idx);
        req_i[idx] = 1'b0;
        step();
    endtask

    initial begin
        logic [1:0] exp_grant;
        logic [1:0] ack_seen;

        rstn_i   = 1'b0;
        req_i    = 2'b00;
        we_i     = 2'b00;
        addr_i   = 4'h0;
        wdata_i  = 64'h0;
        load_en  = 1'b0;
        load_val = 32'h0;

        step();
        step();
        checkOutput("rst_bus", bus_word(), 32'h0);
        checkOutput("rst_ack", 32'(ack_o), 32'h0);
        checkOutput("rst_rdata", rdata_o, 32'h0);
        rstn_i = 1'b1;
        step();

        // Single write: control = 3 starts the counter.
        applyStimulus(0, 1'b1, 2'b11, 32'h0000_0003);
        step();
        checkOutput("sw_p0_bus", bus_word(), exp_bus(1'b1, 1'b0, 1'b1, 2'b11, 16'h0003));
        step();
        checkOutput("sw_fin_ack", 32'(ack_o), 32'h1);
        checkOutput("sw_fin_bus", bus_word(), 32'h0);
        checkOutput("sw_fin_rdata", rdata_o, 32'h0);
        finish_txn(0);

        // Pair write 32'h0002_0010 from requester 1, checked cycle by cycle.
        applyStimulus(1, 1'b1, 2'b00, 32'h0002_0010);
        step();
        checkOutput("pw_p0_bus", bus_word(), exp_bus(1'b1, 1'b0, 1'b1, 2'b00, 16'h0010));
        checkOutput("pw_p0_ack", 32'(ack_o), 32'h0);
        step();
        checkOutput("pw_p1_bus", bus_word(), exp_bus(1'b1, 1'b0, 1'b1, 2'b01, 16'h0002));
        step();
        checkOutput("pw_fin_ack", 32'(ack_o), 32'h2);
        checkOutput("pw_fin_bus", bus_word(), 32'h0);
        finish_txn(1);

        // Max = 32'h0001_FFFF so the counter crosses the 16-bit carry.
        applyStimulus(1, 1'b1, 2'b00, 32'h0001_FFFF);
        wait_ack("maxw", 2'b10, 3);
        finish_txn(1);

        // Status before any wrap reads zero.
        applyStimulus(0, 1'b0, 2'b10, 32'h0);
        wait_ack("stat0", 2'b01, 2);
        checkOutput("stat0_rdata", rdata_o, 32'h0);
        finish_txn(0);

        // Counter preloaded to 0000_FFFF; it reads 0001_0000 at the low-read edge.
        load_val = 32'h0000_FFFF;
        load_en  = 1'b1;
        step();
        load_en  = 1'b0;
        applyStimulus(0, 1'b0, 2'b00, 32'h0);
        wait_ack("pr", 2'b01, 3);
        checkOutput("pr_rdata", rdata_o, 32'h0001_0000);
        finish_txn(0);

        // Let the counter wrap at max, then read status from requester 1.
        load_val = 32'h0001_FFFE;
        load_en  = 1'b1;
        step();
        load_en  = 1'b0;
        repeat (3) step();
        applyStimulus(1, 1'b0, 2'b10, 32'h0);
        wait_ack("stat1", 2'b10, 2);
        checkOutput("stat1_rdata", rdata_o, 32'h0000_0001);
        finish_txn(1);
        checkOutput("stat1_hold_rdata", rdata_o, 32'h0000_0001);
        checkOutput("stat1_hold_ack", 32'(ack_o), 32'h0);

        // Contention: both requesters hold pair reads continuously.
        applyStimulus(0, 1'b0, 2'b00, 32'h0);
        applyStimulus(1, 1'b0, 2'b00, 32'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef TIMER_ARB_FIXED_PRIO_EN
            exp_grant = 2'b01;
`else
            exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            wait_ack($sformatf("cont%0d", k), exp_grant, (k == 0) ? 3 : 4);
        end
        req_i = 2'b00;
        step();
        checkOutput("cont_pair_order", 32'(pair_err), 32'h0);

        // Reset during P1 of a pair read.
        applyStimulus(0, 1'b0, 2'b00, 32'h0);
        step();
        step();
        checkOutput("rmid_p1_bus", bus_word(), exp_bus(1'b1, 1'b1, 1'b0, 2'b01, 16'h0000));
        rstn_i = 1'b0;
        #1;
        checkOutput("rmid_bus", bus_word(), 32'h0);
        checkOutput("rmid_ack", 32'(ack_o), 32'h0);
        checkOutput("rmid_rdata", rdata_o, 32'h0);
        ack_seen = 2'b00;
        repeat (3) begin
            step();
            ack_seen = ack_seen | ack_o;
        end
        checkOutput("rmid_no_ack", 32'(ack_seen), 32'h0);

        // After release both request; requester 0 must win first.
        applyStimulus(1, 1'b0, 2'b00, 32'h0);
        rstn_i = 1'b1;
        wait_ack("post_rst0", 2'b01, 3);
        finish_txn(0);
`ifdef TIMER_ARB_FIXED_PRIO_EN
        wait_ack("post_rst1", 2'b10, 3);
`else
        wait_ack("post_rst1", 2'b10, 3);
`endif
        finish_txn(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
